// File: rtl/mbinit_repairclk_partner_if.sv
// Sideband message channel between the REPAIRCLK partner and the sideband block.
// The slave side is the partner FSM. The master side is the remote and TX logic.
interface mbinit_repairclk_partner_if;
    logic [3:0] i_Rx_SbMessage;
    logic       i_msg_valid;
    logic       i_Busy_SideBand;
    logic       i_falling_edge_busy;
    logic [3:0] o_TX_SbMessage;
    logic       o_ValidOutDatat_ModulePartner;

    modport master (
        output i_Rx_SbMessage, i_msg_valid, i_Busy_SideBand, i_falling_edge_busy,
        input  o_TX_SbMessage, o_ValidOutDatat_ModulePartner
    );
    modport slave (
        input  i_Rx_SbMessage, i_msg_valid, i_Busy_SideBand, i_falling_edge_busy,
        output o_TX_SbMessage, o_ValidOutDatat_ModulePartner
    );
endinterface

// File: rtl/mbinit_repairclk_partner.sv
// MBINIT.REPAIRCLK responder: answers init/result/done requests and counts clock-repair
// pattern hits on RCKP/RCKN/RTRK, then reports a per-lane pass/fail result.
module mbinit_repairclk_partner #(
    parameter int DET_THRESH = 16,
    parameter int CNT_W      = 5
) (
    input  logic                            CLK,
    input  logic                            rst_n,
    input  logic                            i_REPAIRCLK_en,
    mbinit_repairclk_partner_if.slave       sb,
    input  logic                            i_RCKP_hit,
    input  logic                            i_RCKN_hit,
    input  logic                            i_RTRK_hit,
    output logic [2:0]                      o_Clock_Result_logged,
    output logic                            o_detector_enable,
    output logic                            o_MBINIT_REPAIRCLK_ModulePartner_end
);
    localparam logic [3:0] MSG_INIT_REQ    = 4'b0001;
    localparam logic [3:0] MSG_INIT_RESP   = 4'b0010;
    localparam logic [3:0] MSG_RESULT_REQ  = 4'b0011;
    localparam logic [3:0] MSG_RESULT_RESP = 4'b0100;
    localparam logic [3:0] MSG_DONE_REQ    = 4'b0101;
    localparam logic [3:0] MSG_DONE_RESP   = 4'b0110;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] THRESH    = CNT_W'(DET_THRESH);

    typedef enum logic [3:0] {
        S_IDLE, S_CHK_INIT, S_BUSY_INIT, S_INIT_RESP, S_DETECT, S_BUSY_RESULT,
        S_RESULT_RESP, S_WAIT_DONE, S_BUSY_DONE, S_DONE_RESP, S_DONE
    } state_t;

    state_t state, nxt;
    logic [2:0]            hit, pass_nxt, res_q;
    logic [2:0][CNT_W-1:0] cnt, cnt_nxt;
    logic                  req_init, req_result, req_done;

    assign hit        = {i_RTRK_hit, i_RCKN_hit, i_RCKP_hit};
    assign req_init   = sb.i_msg_valid && (sb.i_Rx_SbMessage == MSG_INIT_REQ);
    assign req_result = sb.i_msg_valid && (sb.i_Rx_SbMessage == MSG_RESULT_REQ);
    assign req_done   = sb.i_msg_valid && (sb.i_Rx_SbMessage == MSG_DONE_REQ);

    always_comb begin
        nxt = state;
        if (!i_REPAIRCLK_en && state != S_IDLE) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:        if (i_REPAIRCLK_en)          nxt = S_CHK_INIT;
                S_CHK_INIT:    if (req_init)                nxt = S_BUSY_INIT;
                S_BUSY_INIT:   if (!sb.i_Busy_SideBand)     nxt = S_INIT_RESP;
                S_INIT_RESP:   if (sb.i_falling_edge_busy)  nxt = S_DETECT;
                S_DETECT:      if (req_result)              nxt = S_BUSY_RESULT;
                S_BUSY_RESULT: if (!sb.i_Busy_SideBand)     nxt = S_RESULT_RESP;
                S_RESULT_RESP: if (sb.i_falling_edge_busy)  nxt = S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (req_done)        nxt = S_BUSY_DONE;
                    else if (req_result) nxt = S_BUSY_RESULT;
                end
                S_BUSY_DONE:   if (!sb.i_Busy_SideBand)     nxt = S_DONE_RESP;
                S_DONE_RESP:   if (sb.i_falling_edge_busy)  nxt = S_DONE;
                S_DONE:                                     nxt = S_DONE;
                default:                                    nxt = S_IDLE;
            endcase
        end
    end

    // cnt_nxt includes a hit arriving alongside the result_req, so the latch sees it
    for (genvar g = 0; g < 3; g++) begin : g_lane
        assign cnt_nxt[g]  = (state == S_DETECT && hit[g] && cnt[g] != CNT_MAX)
                             ? cnt[g] + 1'b1 : cnt[g];
        assign pass_nxt[g] = (cnt_nxt[g] >= THRESH);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state                                <= S_IDLE;
            cnt                                  <= '0;
            res_q                                <= '0;
            sb.o_TX_SbMessage                    <= '0;
            sb.o_ValidOutDatat_ModulePartner     <= 1'b0;
            o_Clock_Result_logged                <= '0;
            o_detector_enable                    <= 1'b0;
            o_MBINIT_REPAIRCLK_ModulePartner_end <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt == S_IDLE || (nxt == S_DETECT && state != S_DETECT)) cnt <= '0;
            else                                                         cnt <= cnt_nxt;
            // only a fresh result_req from DETECT evaluates; WAIT_DONE retries resend res_q
            if (nxt == S_IDLE)                                  res_q <= '0;
            else if (state == S_DETECT && nxt == S_BUSY_RESULT) res_q <= pass_nxt;
            sb.o_TX_SbMessage <= (nxt == S_INIT_RESP)   ? MSG_INIT_RESP   :
                                 (nxt == S_RESULT_RESP) ? MSG_RESULT_RESP :
                                 (nxt == S_DONE_RESP)   ? MSG_DONE_RESP   : 4'b0000;
            sb.o_ValidOutDatat_ModulePartner     <= (nxt == S_INIT_RESP) || (nxt == S_RESULT_RESP)
                                                    || (nxt == S_DONE_RESP);
            o_Clock_Result_logged                <= (nxt == S_RESULT_RESP) ? res_q : 3'b000;
            o_detector_enable                    <= (nxt == S_DETECT);
            o_MBINIT_REPAIRCLK_ModulePartner_end <= (nxt == S_DONE);
        end
    end
endmodule

// File: doc/mbinit_repairclk_partner.md
Name: mbinit_repairclk_partner

Overview:
- Module-partner (responder) side of the MBINIT.REPAIRCLK step in the LTSM.
- Answers the remote REPAIRCLK init/result/done sideband requests.
- Counts the clock-repair patterns received on the RCKP, RCKN and RTRK lanes, then reports a 3-bit per-lane pass/fail result.
- Its end flag is the enable for the REPAIRVAL module-partner stage directly downstream.

Parameters:
DET_THRESH, 16, minimum detected pattern iterations for a lane to pass
CNT_W, 5, per-lane counter width; counters saturate at 2^CNT_W-1; DET_THRESH must be <= 2^CNT_W-1

Ports:
CLK  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_REPAIRCLK_en  in  1  level enable from the MBINIT sequencer; low aborts to IDLE
i_Rx_SbMessage  in  4  decoded received sideband message code
i_msg_valid  in  1  qualifies i_Rx_SbMessage for one cycle
i_Busy_SideBand  in  1  sideband TX busy
i_falling_edge_busy  in  1  one-cycle pulse when the sideband TX finishes a message
i_RCKP_hit  in  1  one-cycle pulse per detected pattern iteration on RCKP
i_RCKN_hit  in  1  one-cycle pulse per detected pattern iteration on RCKN
i_RTRK_hit  in  1  one-cycle pulse per detected pattern iteration on RTRK
o_TX_SbMessage  out  4  message code to transmit
o_ValidOutDatat_ModulePartner  out  1  TX request, held while in a *_RESP state
o_Clock_Result_logged  out  3  {RTRK,RCKN,RCKP} pass bits carried with result_resp
o_detector_enable  out  1  enables the clock-pattern comparators
o_MBINIT_REPAIRCLK_ModulePartner_end  out  1  step complete, level

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE.
- Message codes:
  - init_req 0001, init_resp 0010
  - result_req 0011, result_resp 0100
  - done_req 0101, done_resp 0110
- A message is accepted only when i_msg_valid=1.
- Two-process FSM; outputs are registered decodes of the next state, so each output is valid in the same cycle the state becomes current.
- States and transitions:
  - IDLE: go to CHK_INIT_REQ when en=1.
  - CHK_INIT_REQ: accepted init_req -> BUSY_INIT.
  - BUSY_INIT: Busy=0 -> INIT_RESP.
  - INIT_RESP: drive TX=0010 and valid=1; falling_edge_busy -> DETECT.
  - DETECT:
    - o_detector_enable=1; counters cleared in the cycle DETECT is entered.
    - Each hit pulse increments its lane counter, saturating.
    - Accepted result_req -> BUSY_RESULT.
    - done_req and other codes are ignored.
  - BUSY_RESULT: counters frozen; result bit[i] = (cnt[i] >= DET_THRESH), latched on entry; Busy=0 -> RESULT_RESP.
  - RESULT_RESP: drive TX=0100, valid=1, o_Clock_Result_logged=latched bits; falling_edge_busy -> WAIT_DONE.
  - WAIT_DONE:
    - Accepted done_req -> BUSY_DONE.
    - Accepted result_req -> BUSY_RESULT, which resends the same latched result; counters are not re-evaluated.
  - BUSY_DONE: Busy=0 -> DONE_RESP.
  - DONE_RESP: drive TX=0110, valid=1; falling_edge_busy -> DONE.
  - DONE: o_..._end=1, held until en drops.
- o_Clock_Result_logged is 0 outside RESULT_RESP.
- TX code and valid are 0 outside *_RESP states.
- Abort: en=0 in any non-IDLE state -> IDLE on the next edge. All outputs go to 0 with that edge; counters are cleared.
- A hit pulse in the same cycle as an accepted result_req is counted.
- Hit pulses outside DETECT are ignored.
- Unexpected or invalid messages never change state.
- i_falling_edge_busy outside *_RESP states is ignored.
- Illegal state encoding -> IDLE.

Test Plan:
1. Nominal pass: en=1, init_req -> init_resp (0010, valid=1) sent; 20 hits on every lane; result_req -> result_resp 0100 with o_Clock_Result_logged=3'b111; done_req -> 0110, then end=1.
2. Partial fail: RCKP=16 hits, RCKN=15, RTRK=0 -> o_Clock_Result_logged=3'b001.
3. Saturation: 40 RTRK hits with CNT_W=5 -> counter holds 31, bit2=1; no wrap to 8.
4. Busy gating: Busy=1 held 10 cycles after result_req -> stays in BUSY_RESULT with valid=0; Busy falls -> valid=1 next cycle. Repeated result_req in WAIT_DONE -> identical result resent.
5. Abort: en drops during DETECT and during DONE_RESP -> next cycle all outputs 0, state IDLE. Re-enable -> counters start from 0.
6. Filtering: init_req with i_msg_valid=0, done_req during DETECT, and hits before init_resp -> no state change, and no effect on the counts.
